// File: rtl/card_dealer.sv
// ============================================================================
//  Module   : card_dealer
//  Purpose  : LFSR card source, four-card opening deal and player/dealer
//             request arbiter. Define CARD_DEALER_DECK_TRACK_EN for finite
//             decks with per-rank tracking; otherwise the deck is infinite.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module card_dealer #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          DECKS = 1
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       deal_start_i,
  input  logic       p_req_i,
  input  logic       d_req_i,
  output logic [3:0] card_o,
  output logic       card_valid_o,
  output logic       card_dest_o,
  output logic       ready_o,
  output logic       deck_empty_o,
  output logic [7:0] cards_left_o
);

  localparam logic [7:0] FULL_DECK = 8'(52 * DECKS);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_INIT  = 2'd1;
  localparam logic [1:0] ST_SERVE = 2'd2;
  localparam logic [1:0] ST_EMPTY = 2'd3;

  logic [1:0]  state_q, state_d;
  logic [15:0] lfsr_q, lfsr_d;
  logic [1:0]  deal_idx_q, deal_idx_d;
  logic [1:0]  pend_q, pend_d;          // bit0 player, bit1 dealer
  logic        last_q, last_d;
  logic        draw_q, draw_d;
  logic        draw_dest_q, draw_dest_d;
  logic [3:0]  card_q, card_d;
  logic        card_valid_q, card_valid_d;
  logic        card_dest_q, card_dest_d;
  logic        ready_q, ready_d;

  logic [3:0]  w_rank;
  logic        w_in_range;
  logic        w_accept;
  logic [3:0]  w_value;
  logic        w_fb;
  logic        w_grant_ok;
  logic        w_grant_dest;
  logic        w_init_draw;
  logic        w_serve_draw;
  logic        w_drawing;
  logic        w_dest;

`ifdef CARD_DEALER_DECK_TRACK_EN
  localparam int                  CNT_W      = $clog2(4 * DECKS + 1);
  localparam logic [CNT_W-1:0]    RANK_LIMIT = CNT_W'(4 * DECKS);

  logic [CNT_W-1:0] cnt_q [0:12];
  logic [CNT_W-1:0] cnt_d [0:12];
  logic [7:0]       left_q, left_d;
  logic             empty_q, empty_d;
  logic [3:0]       w_rank_idx;

  assign w_rank_idx   = w_in_range ? (w_rank - 4'd1) : 4'd0;
  assign w_accept     = w_in_range && (cnt_q[w_rank_idx] < RANK_LIMIT);
  assign cards_left_o = left_q;
  assign deck_empty_o = empty_q;
`else
  assign w_accept     = w_in_range;
  assign cards_left_o = FULL_DECK;
  assign deck_empty_o = 1'b0;
`endif

  assign w_rank     = lfsr_q[3:0];
  assign w_in_range = (w_rank != 4'd0) && (w_rank <= 4'd13);
  assign w_value    = (w_rank > 4'd10) ? 4'd10 : w_rank;
  assign w_fb       = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];

  // A new grant waits out the strobe cycle so consecutive strobes never touch.
  assign w_grant_ok   = (state_q == ST_SERVE) && !draw_q && !card_valid_q && (pend_q != 2'b00);
  assign w_grant_dest = (pend_q == 2'b11) ? ~last_q : pend_q[1];
  assign w_init_draw  = (state_q == ST_INIT) && !card_valid_q;
  assign w_serve_draw = (state_q == ST_SERVE) && (draw_q || w_grant_ok);
  assign w_drawing    = w_init_draw || w_serve_draw;
  assign w_dest       = (state_q == ST_INIT) ? deal_idx_q[0] :
                        (draw_q ? draw_dest_q : w_grant_dest);

  always_comb begin
    state_d      = state_q;
    lfsr_d       = {w_fb, lfsr_q[15:1]};
    deal_idx_d   = deal_idx_q;
    pend_d       = pend_q;
    last_d       = last_q;
    draw_d       = draw_q;
    draw_dest_d  = draw_dest_q;
    card_d       = 4'd0;
    card_valid_d = 1'b0;
    card_dest_d  = 1'b0;
    ready_d      = ready_q | (state_q == ST_SERVE);
`ifdef CARD_DEALER_DECK_TRACK_EN
    cnt_d        = cnt_q;
    left_d       = left_q;
    empty_d      = empty_q;
`endif

    if (state_q == ST_SERVE) begin
      pend_d = pend_q | {d_req_i, p_req_i};
    end
    if (state_q == ST_EMPTY) begin
      pend_d = 2'b00;
    end

    if (w_drawing && w_accept) begin
      card_d       = w_value;
      card_valid_d = 1'b1;
      card_dest_d  = w_dest;
`ifdef CARD_DEALER_DECK_TRACK_EN
      cnt_d[w_rank_idx] = cnt_q[w_rank_idx] + CNT_W'(1);
      left_d            = left_q - 8'd1;
`endif
      if (state_q == ST_INIT) begin
        deal_idx_d = deal_idx_q + 2'd1;
        if (deal_idx_q == 2'd3) begin
          state_d = ST_SERVE;
        end
      end else begin
        pend_d[w_dest] = 1'b0;
        last_d         = w_dest;
        draw_d         = 1'b0;
`ifdef CARD_DEALER_DECK_TRACK_EN
        if (left_q == 8'd1) begin
          state_d = ST_EMPTY;
          empty_d = 1'b1;
          pend_d  = 2'b00;
        end
`endif
      end
    end else if (w_serve_draw) begin
      draw_d      = 1'b1;
      draw_dest_d = w_dest;
    end

    // A new round overrides everything else, including same-cycle requests.
    if (deal_start_i) begin
      state_d      = ST_INIT;
      deal_idx_d   = 2'd0;
      pend_d       = 2'b00;
      last_d       = 1'b0;
      draw_d       = 1'b0;
      draw_dest_d  = 1'b0;
      card_d       = 4'd0;
      card_valid_d = 1'b0;
      card_dest_d  = 1'b0;
      ready_d      = 1'b0;
`ifdef CARD_DEALER_DECK_TRACK_EN
      for (int i = 0; i < 13; i++) begin
        cnt_d[i] = '0;
      end
      left_d  = FULL_DECK;
      empty_d = 1'b0;
`endif
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q      <= ST_IDLE;
      lfsr_q       <= SEED;
      deal_idx_q   <= 2'd0;
      pend_q       <= 2'b00;
      last_q       <= 1'b0;
      draw_q       <= 1'b0;
      draw_dest_q  <= 1'b0;
      card_q       <= 4'd0;
      card_valid_q <= 1'b0;
      card_dest_q  <= 1'b0;
      ready_q      <= 1'b0;
`ifdef CARD_DEALER_DECK_TRACK_EN
      for (int i = 0; i < 13; i++) begin
        cnt_q[i] <= '0;
      end
      left_q  <= FULL_DECK;
      empty_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_d;
      deal_idx_q   <= deal_idx_d;
      pend_q       <= pend_d;
      last_q       <= last_d;
      draw_q       <= draw_d;
      draw_dest_q  <= draw_dest_d;
      card_q       <= card_d;
      card_valid_q <= card_valid_d;
      card_dest_q  <= card_dest_d;
      ready_q      <= ready_d;
`ifdef CARD_DEALER_DECK_TRACK_EN
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      empty_q <= empty_d;
`endif
    end
  end

  assign card_o       = card_q;
  assign card_valid_o = card_valid_q;
  assign card_dest_o  = card_dest_q;
  assign ready_o      = ready_q;

endmodule

`default_nettype wire
